// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with ALU-control decode, a registered result
// path and an iterative shift-add multiplier that stalls issue while busy.
module alu_exec_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             valid_o,
  output logic             illegal_o,
  output logic             busy_o,
  output logic [3:0]       ALUCtrl_o
);

  // Multiplier iteration count and a counter wide enough to hold it.
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  localparam logic [3:0] CTRL_AND = 4'h0;
  localparam logic [3:0] CTRL_OR  = 4'h1;
  localparam logic [3:0] CTRL_ADD = 4'h2;
  localparam logic [3:0] CTRL_SUB = 4'h6;
  localparam logic [3:0] CTRL_SLT = 4'h7;
  localparam logic [3:0] CTRL_MUL = 4'hA;
  localparam logic [3:0] CTRL_ILL = 4'hE;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] mcand_q,   mcand_d;   // multiplicand, shifted left per step
  logic [WIDTH-1:0] mplier_q,  mplier_d;  // multiplier, shifted right per step
  logic [WIDTH-1:0] acc_q,     acc_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             zero_q,    zero_d;
  logic             valid_q,   valid_d;
  logic             illegal_q, illegal_d;

  logic [3:0]       ctrl;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] mac_sum;
  logic             slt_lt;

  // Decode ALU control from the main-control op class and funct field.
  always_comb begin
    ctrl = CTRL_ILL;
    unique case (ALUOp_i)
      2'b00: ctrl = CTRL_ADD;
      2'b01: ctrl = CTRL_SUB;
      2'b11: ctrl = CTRL_SLT;
      2'b10: begin
        unique case (funct_i)
          6'b100000: ctrl = CTRL_ADD;
          6'b100010: ctrl = CTRL_SUB;
          6'b100100: ctrl = CTRL_AND;
          6'b100101: ctrl = CTRL_OR;
          6'b101010: ctrl = CTRL_SLT;
          6'b011000: ctrl = CTRL_MUL;
          default:   ctrl = CTRL_ILL;
        endcase
      end
      default: ctrl = CTRL_ILL;
    endcase
  end

  assign ALUCtrl_o = ctrl;

  // Single-cycle result; MUL and ILLEGAL yield 0 here (MUL never uses it).
  always_comb begin
    slt_lt  = ($signed(src1_i) < $signed(src2_i));
    alu_res = '0;
    unique case (ctrl)
      CTRL_ADD: alu_res = src1_i + src2_i;
      CTRL_SUB: alu_res = src1_i - src2_i;
      CTRL_AND: alu_res = src1_i & src2_i;
      CTRL_OR:  alu_res = src1_i | src2_i;
      CTRL_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_lt};
      default:  alu_res = '0;
    endcase
  end

  // One multiplier step: shifted multiplicand times the low multiplier bits.
  // Only the low WIDTH bits are kept, which is correct for signed operands too.
  always_comb begin
    partial = '0;
    for (int b = 0; b < BITS_PER_CYCLE; b++) begin
      if (mplier_q[b]) partial = partial + (mcand_q << b);
    end
    mac_sum = acc_q + partial;
  end

  // Next-state: issue in IDLE, iterate or abort in MUL.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    valid_d   = 1'b0;
    illegal_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (valid_i && !flush_i) begin
          if (ctrl == CTRL_MUL) begin
            state_d  = S_MUL;
            mcand_d  = src1_i;
            mplier_d = src2_i;
            acc_d    = '0;
            cnt_d    = CW'(N);
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            valid_d   = 1'b1;
            illegal_d = (ctrl == CTRL_ILL);
          end
        end
      end
      S_MUL: begin
        if (flush_i) begin
          // Abort: drop the product, keep the last visible result.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d    = mac_sum;
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d  = S_IDLE;
            result_d = mac_sum;
            zero_d   = (mac_sum == '0);
            valid_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset overrides flush and issue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign valid_o   = valid_q;
  assign illegal_o = illegal_q;
  assign busy_o    = (state_q == S_MUL);

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vector table for single-cycle ops plus
// hand-written MUL, stall, flush and reset sequences.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_i, valid_i, valid4_i, flush_i;
  logic [1:0]  ALUOp_i;
  logic [5:0]  funct_i;
  logic [31:0] src1_i, src2_i;

  logic [31:0] result_o, result4_o;
  logic        zero_o, valid_o, illegal_o, busy_o;
  logic        zero4_o, valid4_o, illegal4_o, busy4_o;
  logic [3:0]  ALUCtrl_o, ALUCtrl4_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
    .ALUOp_i(ALUOp_i), .funct_i(funct_i), .src1_i(src1_i), .src2_i(src2_i),
    .result_o(result_o), .zero_o(zero_o), .valid_o(valid_o),
    .illegal_o(illegal_o), .busy_o(busy_o), .ALUCtrl_o(ALUCtrl_o));

  alu_exec_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid4_i), .flush_i(flush_i),
    .ALUOp_i(ALUOp_i), .funct_i(funct_i), .src1_i(src1_i), .src2_i(src2_i),
    .result_o(result4_o), .zero_o(zero4_o), .valid_o(valid4_o),
    .illegal_o(illegal4_o), .busy_o(busy4_o), .ALUCtrl_o(ALUCtrl4_o));

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a, b;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        zero, ill;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    ALUOp_i = op; funct_i = fn; src1_i = a; src2_i = b;
  endtask

  // Step cycles while busy, counting them and any stray valid pulses.
  task automatic wait_idle(output int cyc, output int stray);
    cyc = 0; stray = 0;
    while (busy_o && cyc < 100) begin
      if (valid_o) stray++;
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, stray;
    vecs[0]  = '{2'b10, 6'b100000, 32'd5,        32'd7,        4'h2, 32'd12,       1'b0, 1'b0};
    vecs[1]  = '{2'b10, 6'b100010, 32'd3,        32'd5,        4'h6, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[2]  = '{2'b10, 6'b100100, 32'hF0F0,     32'hFF00,     4'h0, 32'hF000,     1'b0, 1'b0};
    vecs[3]  = '{2'b10, 6'b100101, 32'h0F,       32'hF0,       4'h1, 32'hFF,       1'b0, 1'b0};
    vecs[4]  = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,        4'h7, 32'd1,        1'b0, 1'b0};
    vecs[5]  = '{2'b00, 6'b111111, 32'd10,       32'd20,       4'h2, 32'd30,       1'b0, 1'b0};
    vecs[6]  = '{2'b01, 6'b000000, 32'd9,        32'd9,        4'h6, 32'd0,        1'b1, 1'b0};
    vecs[7]  = '{2'b11, 6'b000000, 32'd1,        32'hFFFFFFFF, 4'h7, 32'd0,        1'b1, 1'b0};
    vecs[8]  = '{2'b10, 6'b101010, 32'h7FFFFFFF, 32'h80000000, 4'h7, 32'd0,        1'b1, 1'b0};
    vecs[9]  = '{2'b10, 6'b100000, 32'hFFFFFFFF, 32'd1,        4'h2, 32'd0,        1'b1, 1'b0};
    vecs[10] = '{2'b10, 6'b111111, 32'd4,        32'd4,        4'hE, 32'd0,        1'b1, 1'b1};
    vecs[11] = '{2'b10, 6'b100000, 32'd1,        32'd1,        4'h2, 32'd2,        1'b0, 1'b0};

    // Reset then idle.
    rst_i = 1'b1; valid_i = 1'b0; valid4_i = 1'b0; flush_i = 1'b0;
    drive(2'b00, 6'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst_result", result_o, 32'd0);
      chk("rst_zero",   zero_o,   1);
      chk("rst_valid",  valid_o,  0);
      chk("rst_busy",   busy_o,   0);
    end

    // Single-cycle ops issued back-to-back on consecutive edges.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b);
      valid_i = 1'b1;
      #1 chk($sformatf("v%0d_ctrl", i), ALUCtrl_o, vecs[i].ctrl);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i),   valid_o,   1);
      chk($sformatf("v%0d_result", i),  result_o,  vecs[i].res);
      chk($sformatf("v%0d_zero", i),    zero_o,    vecs[i].zero);
      chk($sformatf("v%0d_illegal", i), illegal_o, vecs[i].ill);
    end
    valid_i = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid", valid_o, 0);
    chk("hold_result", result_o, 32'd2);

    // MUL 7 x -3 on the 1-bit-per-cycle unit.
    @(negedge clk);
    drive(2'b10, 6'b011000, 32'd7, 32'hFFFFFFFD);
    valid_i = 1'b1;
    #1 chk("mul_ctrl", ALUCtrl_o, 4'hA);
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("mul_accept_valid", valid_o, 0);
    wait_idle(cyc, stray);
    chk("mul_busy_cycles", cyc, 32);
    chk("mul_stray_valid", stray, 0);
    chk("mul_valid",  valid_o,  1);
    chk("mul_result", result_o, 32'hFFFFFFEB);
    chk("mul_zero",   zero_o,   0);

    // Same product on the 4-bits-per-cycle unit.
    @(negedge clk);
    valid4_i = 1'b1;
    @(posedge clk); #1;
    valid4_i = 1'b0;
    cyc = 0;
    while (busy4_o && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
    chk("mul4_busy_cycles", cyc, 8);
    chk("mul4_valid",  valid4_o,  1);
    chk("mul4_result", result4_o, 32'hFFFFFFEB);
    chk("mul4_zero",   zero4_o,   0);

    // MUL followed by an ADD held on valid_i for the whole stall.
    @(negedge clk);
    drive(2'b10, 6'b011000, 32'd6, 32'd7);
    valid_i = 1'b1;
    @(posedge clk); #1;
    drive(2'b10, 6'b100000, 32'd2, 32'd3);
    wait_idle(cyc, stray);
    chk("stall_busy_cycles", cyc, 32);
    chk("stall_stray_valid", stray, 0);
    chk("stall_mul_valid",  valid_o,  1);
    chk("stall_mul_result", result_o, 32'd42);
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("stall_add_valid",  valid_o,  1);
    chk("stall_add_result", result_o, 32'd5);
    chk("stall_add_busy",   busy_o,   0);

    // Flush at busy cycle 10 of a MUL.
    @(negedge clk);
    drive(2'b10, 6'b011000, 32'd6, 32'd7);
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 chk("flush_pre_busy", busy_o, 1);
    @(negedge clk); flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_busy",   busy_o,   0);
    chk("flush_valid",  valid_o,  0);
    chk("flush_result", result_o, 32'd5);
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o) chk("flush_late_valid", valid_o, 0);
    end

    // Flush with a simultaneous issue in IDLE: nothing accepted.
    @(negedge clk);
    drive(2'b10, 6'b100000, 32'd100, 32'd1);
    valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_issue_valid",  valid_o,  0);
    chk("flush_issue_result", result_o, 32'd5);

    // Reset at busy cycle 10 of a MUL.
    @(negedge clk);
    drive(2'b10, 6'b011000, 32'd6, 32'd7);
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 chk("rstm_pre_busy", busy_o, 1);
    @(negedge clk); rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("rstm_busy",   busy_o,   0);
    chk("rstm_valid",  valid_o,  0);
    chk("rstm_result", result_o, 32'd0);
    chk("rstm_zero",   zero_o,   1);
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o) chk("rstm_late_valid", valid_o, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
